// File: rtl/dmem_responder_if.sv
// Purpose: one requester port of the shared data memory (request, grant, response).
// Latency: gnt is combinational from req; rvalid/rdata/err arrive one cycle after gnt.
// Backpressure: requester holds req and its fields stable until gnt is seen high.
interface dmem_port_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_responder.sv
// Purpose: two-port arbitrated access to a single-ported DEPTH x 32 data memory, with range checking.
// Latency: grant is combinational; load data or error response registered, 1 cycle after grant.
// Backpressure: the losing port sees gnt low and keeps requesting; one access per cycle sustained.
// Build option: define DMEM_RR_ARB_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module dmem_responder #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic        clk,
    input  logic        rst,
    dmem_port_if.slave  p0,
    dmem_port_if.slave  p1
);

    logic [31:0]   mem [DEPTH];
    logic          last_gnt;
    logic          gnt0;
    logic          gnt1;
    logic          acc;
    logic          sel_we;
    logic [31:0]   sel_addr;
    logic [31:0]   sel_wdata;
    logic          in_range;
    logic [AW-1:0] idx;
    logic          rsp;
    logic [31:0]   rsp_dat;

    logic          rvalid0;
    logic          err0;
    logic [31:0]   rdata0;
    logic          rvalid1;
    logic          err1;
    logic [31:0]   rdata1;

    // Arbitration: a lone requester always wins; contention resolved by the configured policy.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (p0.req && p1.req) begin
`ifdef DMEM_RR_ARB_EN
                gnt0 = last_gnt;
                gnt1 = !last_gnt;
`else
                gnt0 = 1'b1;
`endif
            end else begin
                gnt0 = p0.req;
                gnt1 = p1.req;
            end
        end
    end

`ifndef DMEM_RR_ARB_EN
    // Fixed priority keeps last_gnt up to date for observability but never consults it.
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;
`endif

    // Route the granted port's request onto the single memory access path.
    always_comb begin
        sel_we    = p0.we;
        sel_addr  = p0.addr;
        sel_wdata = p0.wdata;
        if (gnt1) begin
            sel_we    = p1.we;
            sel_addr  = p1.addr;
            sel_wdata = p1.wdata;
        end
    end

    assign acc      = gnt0 | gnt1;
    assign in_range = (sel_addr[31:AW] == '0);
    assign idx      = sel_addr[AW-1:0];
    // Loads always answer; stores answer only when they fault.
    assign rsp      = acc && (!sel_we || !in_range);
    assign rsp_dat  = in_range ? mem[idx] : 32'h0;

    // Memory array: cleared by reset, written only by granted in-range stores.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'h0;
            end
        end else if (acc && sel_we && in_range) begin
            mem[idx] <= sel_wdata;
        end
    end

    // Remember the most recent winner; port 0 is favoured first out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= 1'b1;
        end else if (gnt0) begin
            last_gnt <= 1'b0;
        end else if (gnt1) begin
            last_gnt <= 1'b1;
        end
    end

    // Port 0 response: one-cycle rvalid pulse, rdata holds between responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid0 <= 1'b0;
            err0    <= 1'b0;
            rdata0  <= 32'h0;
        end else begin
            rvalid0 <= gnt0 && rsp;
            err0    <= gnt0 && rsp && !in_range;
            if (gnt0 && rsp) begin
                rdata0 <= rsp_dat;
            end
        end
    end

    // Port 1 response: one-cycle rvalid pulse, rdata holds between responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid1 <= 1'b0;
            err1    <= 1'b0;
            rdata1  <= 32'h0;
        end else begin
            rvalid1 <= gnt1 && rsp;
            err1    <= gnt1 && rsp && !in_range;
            if (gnt1 && rsp) begin
                rdata1 <= rsp_dat;
            end
        end
    end

    assign p0.gnt    = gnt0;
    assign p1.gnt    = gnt1;
    assign p0.rvalid = rvalid0;
    assign p0.err    = err0;
    assign p0.rdata  = rdata0;
    assign p1.rvalid = rvalid1;
    assign p1.err    = err1;
    assign p1.rdata  = rdata1;

endmodule

// File: tb/tb_dmem_responder.sv
// Purpose: scoreboard bench for dmem_responder; per-port op queues drive requests, expected responses are queued at grant.
// Latency: expects rvalid exactly one cycle after a grant that produces a response.
// Backpressure: an op stays at the head of its port queue until the bench model predicts its grant.
module tb_dmem_responder;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } op_t;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;

    dmem_port_if p0_if();
    dmem_port_if p1_if();

    dmem_responder #(.DEPTH(32), .AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .p0  (p0_if),
        .p1  (p1_if)
    );

    always #5 clk = ~clk;

    op_t         ops0[$];
    op_t         ops1[$];
    rsp_t        sb0[$];
    rsp_t        sb1[$];
    logic [31:0] mmem [32];
    logic        m_last;
    int          hist[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic op_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        op_t o;
        o.we    = we;
        o.addr  = addr;
        o.wdata = wdata;
        return o;
    endfunction

    task automatic drive_inputs();
        op_t z;
        z = mk(1'b0, 32'h0, 32'h0);
        p0_if.req = (ops0.size() != 0);
        p1_if.req = (ops1.size() != 0);
        if (ops0.size() != 0) z = ops0[0]; else z = mk(1'b0, 32'h0, 32'h0);
        p0_if.we = z.we; p0_if.addr = z.addr; p0_if.wdata = z.wdata;
        if (ops1.size() != 0) z = ops1[0]; else z = mk(1'b0, 32'h0, 32'h0);
        p1_if.we = z.we; p1_if.addr = z.addr; p1_if.wdata = z.wdata;
    endtask

    // Apply a granted op to the model; returns 1 when a response is owed next cycle.
    function automatic bit model_apply(input int port, input op_t o);
        rsp_t r;
        bit   owe;
        owe = 1'b1;
        if (o.addr[31:5] != 27'h0) begin
            r.err = 1'b1; r.rdata = 32'h0;
        end else if (o.we) begin
            mmem[o.addr[4:0]] = o.wdata;
            owe = 1'b0;
            r = '0;
        end else begin
            r.err = 1'b0; r.rdata = mmem[o.addr[4:0]];
        end
        if (owe) begin
            if (port == 0) sb0.push_back(r); else sb1.push_back(r);
        end
        return owe;
    endfunction

    task automatic collect(input bit due0, input bit due1);
        rsp_t r;
        check("p0_rvalid", 64'(p0_if.rvalid), 64'(due0));
        check("p1_rvalid", 64'(p1_if.rvalid), 64'(due1));
        if (p0_if.rvalid && sb0.size() != 0) begin
            r = sb0.pop_front();
            check("p0_rsp", 64'({p0_if.err, p0_if.rdata}), 64'(r));
        end
        if (p1_if.rvalid && sb1.size() != 0) begin
            r = sb1.pop_front();
            check("p1_rsp", 64'({p1_if.err, p1_if.rdata}), 64'(r));
        end
    endtask

    // One clock cycle: drive at negedge, check grants, apply model, check responses after the edge.
    task automatic step();
        bit r0, r1, e0, e1, due0, due1;
        op_t o;
        drive_inputs();
        #1;
        r0 = (ops0.size() != 0);
        r1 = (ops1.size() != 0);
        if (r0 && r1) begin
`ifdef DMEM_RR_ARB_EN
            e0 = m_last;
`else
            e0 = 1'b1;
`endif
            e1 = !e0;
        end else begin
            e0 = r0;
            e1 = r1;
        end
        check("p0_gnt", 64'(p0_if.gnt), 64'(e0));
        check("p1_gnt", 64'(p1_if.gnt), 64'(e1));
        due0 = 1'b0;
        due1 = 1'b0;
        if (e0) begin
            o = ops0.pop_front();
            due0 = model_apply(0, o);
            hist.push_back(0);
            m_last = 1'b0;
        end
        if (e1) begin
            o = ops1.pop_front();
            due1 = model_apply(1, o);
            hist.push_back(1);
            m_last = 1'b1;
        end
        @(posedge clk);
        #1;
        collect(due0, due1);
        @(negedge clk);
    endtask

    task automatic run_all();
        int n;
        n = 0;
        while ((ops0.size() != 0 || ops1.size() != 0) && n < 400) begin
            step();
            n++;
        end
        check("ops_drained", 64'(ops0.size() + ops1.size()), 64'd0);
        check("sb_drained", 64'(sb0.size() + sb1.size()), 64'd0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mmem[i] = 32'h0;
        m_last = 1'b1;
        sb0.delete(); sb1.delete(); hist.delete();
        ops0.delete(); ops1.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        p0_if.req = 1'b1; p0_if.we = 1'b0; p0_if.addr = 32'h3; p0_if.wdata = 32'h0;
        p1_if.req = 1'b1; p1_if.we = 1'b1; p1_if.addr = 32'h4; p1_if.wdata = 32'h1;
        #1;
        check("rst_gnt", 64'({p0_if.gnt, p1_if.gnt}), 64'd0);
        @(posedge clk);
        #1;
        check("rst_rvalid", 64'({p0_if.rvalid, p1_if.rvalid, p0_if.err, p1_if.err}), 64'd0);
        check("rst_rdata", 64'({p0_if.rdata, p1_if.rdata}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        p0_if.req = 1'b0;
        p1_if.req = 1'b0;
    endtask

    initial begin
        op_t  o;
        logic [7:0] seq;
        rst = 1'b0;
        p0_if.req = 1'b0; p0_if.we = 1'b0; p0_if.addr = 32'h0; p0_if.wdata = 32'h0;
        p1_if.req = 1'b0; p1_if.we = 1'b0; p1_if.addr = 32'h0; p1_if.wdata = 32'h0;
        @(negedge clk);
        do_reset();

        // Load from a freshly cleared word.
        ops0.push_back(mk(1'b0, 32'd3, 32'h0));
        run_all();
        check("first_load_data", 64'(p0_if.rdata), 64'd0);

        // Store on one port, load it back on the other.
        ops0.push_back(mk(1'b1, 32'd5, 32'hDEADBEEF));
        run_all();
        ops1.push_back(mk(1'b0, 32'd5, 32'h0));
        run_all();
        check("xport_data", 64'(p1_if.rdata), 64'hDEADBEEF);

        // Out-of-range accesses fault and leave the array alone.
        ops0.push_back(mk(1'b1, 32'd0, 32'h12345678));
        ops0.push_back(mk(1'b1, 32'd31, 32'h87654321));
        run_all();
        ops1.push_back(mk(1'b0, 32'h20, 32'h0));
        ops1.push_back(mk(1'b1, 32'hFFFFFFFF, 32'hCAFECAFE));
        run_all();
        ops1.push_back(mk(1'b0, 32'd31, 32'h0));
        ops1.push_back(mk(1'b0, 32'd0, 32'h0));
        run_all();
        check("oob_keep0", 64'(p1_if.rdata), 64'h12345678);

        // Contention straight out of reset: store on p0 and load on p1 of the same word.
        do_reset();
        ops0.push_back(mk(1'b1, 32'd7, 32'h11));
        ops1.push_back(mk(1'b0, 32'd7, 32'h0));
        run_all();
        check("same_word_order", 64'(hist.size() == 2 ? {hist[0][1:0], hist[1][1:0]} : 4'hF), 64'h1);
        check("same_word_data", 64'(p1_if.rdata), 64'h11);

        // Both ports loading continuously for four cycles.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            ops0.push_back(mk(1'b0, 32'(i), 32'h0));
            ops1.push_back(mk(1'b0, 32'(i + 8), 32'h0));
        end
        for (int i = 0; i < 4; i++) step();
        seq = 8'hFF;
        if (hist.size() == 4) seq = {hist[0][1:0], hist[1][1:0], hist[2][1:0], hist[3][1:0]};
`ifdef DMEM_RR_ARB_EN
        check("contend_seq", 64'(seq), 64'h11);
`else
        check("contend_seq", 64'(seq), 64'h00);
`endif
        run_all();

        // Reset right after a load grant drops the response and clears the array.
        ops0.push_back(mk(1'b1, 32'd9, 32'hA5A5A5A5));
        run_all();
        ops0.push_back(mk(1'b0, 32'd9, 32'h0));
        drive_inputs();
        #1;
        check("pre_rst_gnt", 64'(p0_if.gnt), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_drop_rvalid", 64'(p0_if.rvalid), 64'd0);
        check("rst_drop_rdata", 64'(p0_if.rdata), 64'd0);
        model_reset();
        p0_if.req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step();
        for (int i = 0; i < 32; i++) ops1.push_back(mk(1'b0, 32'(i), 32'h0));
        run_all();

        // Mixed random traffic on both ports against the model.
        for (int i = 0; i < 80; i++) begin
            o.we    = 1'($urandom_range(0, 1));
            o.addr  = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFF : 32'($urandom_range(0, 40));
            o.wdata = $urandom;
            if ($urandom_range(0, 1) == 0) ops0.push_back(o); else ops1.push_back(o);
        end
        run_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
